debounce_array: RTL and testbench

Multi-channel push-button conditioner and the parametrised successor to the single-input debouncer. Each of `CHANNELS` raw, asynchronous button inputs is synchronised, polarity-normalised and debounced with an independent stability counter. Per channel, the block produces a clean level, single-cycle press/release pulses and an optional long-press pulse. It sits between the board button pins and the display/mode-control logic of the 7-segment design.

---
 rtl/debounce_array.sv | 114 +++++++++++
 tb/tb_debounce_array.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - multi-channel push-button synchroniser, debouncer and press/long-press detector
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn_raw        raw button pins, asynchronous to clk
//   level          debounced button state, 1 = pressed
//   press          one-cycle pulse on a debounced 0->1 transition
//   release_pulse  one-cycle pulse on a debounced 1->0 transition ("release" is a reserved word)
//   long_press     one-cycle pulse once per press after HOLD_CYCLES of continuous press
module debounce_array #(
  parameter int CHANNELS    = 4,
  parameter int DELAY       = 20000,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 0,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  // Inverting before the synchroniser makes its reset value of 0 mean
  // "released" for both polarities, so no press follows reset.
  logic [CHANNELS-1:0] btn_norm;
  assign btn_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   s;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_norm[g]};
      end
    end

    // Counts consecutive cycles of disagreement; any agreeing cycle
    // restarts the count, so glitches shorter than DELAY are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (s == level_q) begin
          cnt_q <= '0;
        end else if (accept) begin
          cnt_q     <= '0;
          level_q   <= s;
          press_q   <= s;
          release_q <= ~s;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    assign level[g]         = level_q;
    assign press[g]         = press_q;
    assign release_pulse[g] = release_q;

    if (HOLD_CYCLES > 0) begin : g_hold
      localparam int HW = $clog2(HOLD_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
      localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

      logic [HW-1:0] hold_q;
      logic          long_q;

      // Cleared on the edge that raises level, so the pulse lands exactly
      // HOLD_CYCLES cycles after the press pulse. Saturation prevents repeats.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (accept || !level_q) begin
            hold_q <= '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HW'(1);
            long_q <= (hold_q == HOLD_PRE);
          end
        end
      end

      assign long_press[g] = long_q;
    end else begin : g_no_hold
      assign long_press[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - scoreboard bench for debounce_array, active-high and active-low instances
module tb_debounce_array;

  localparam int CH = 4;
  localparam int DL = 4;
  localparam int SY = 2;
  localparam int HD = 10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] raw_hi;
  logic [CH-1:0] raw_lo;
  logic [CH-1:0] lvl_hi, prs_hi, rel_hi, lng_hi;
  logic [CH-1:0] lvl_lo, prs_lo, rel_lo, lng_lo;

  always #5 clk = ~clk;

  debounce_array #(
    .CHANNELS(CH), .DELAY(DL), .SYNC_STAGES(SY), .ACTIVE_LOW(0), .HOLD_CYCLES(HD)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_hi),
    .level(lvl_hi), .press(prs_hi), .release_pulse(rel_hi), .long_press(lng_hi)
  );

  debounce_array #(
    .CHANNELS(CH), .DELAY(DL), .SYNC_STAGES(SY), .ACTIVE_LOW(1), .HOLD_CYCLES(HD)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_lo),
    .level(lvl_lo), .press(prs_lo), .release_pulse(rel_lo), .long_press(lng_lo)
  );

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: level flips when the DELAY samples that have just
  // cleared the synchroniser all disagree with it; long press fires HD
  // edges after a press if level has not dropped since.
  logic [CH-1:0] hist [2][SY+DL];
  logic [CH-1:0] m_lvl [2];
  int            press_edge [2][CH];
  int            cyc = 0;
  exp_t          m_e;
  logic [CH-1:0] m_n, m_p, m_r, m_l;
  logic          flip;

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_n = (d == 0) ? raw_hi : ~raw_lo;
      m_p = '0;
      m_r = '0;
      m_l = '0;
      if (!rst_n) begin
        for (int j = 0; j < SY + DL; j++) hist[d][j] = '0;
        m_lvl[d] = '0;
        for (int c = 0; c < CH; c++) press_edge[d][c] = -100000;
      end else begin
        for (int j = SY + DL - 1; j > 0; j--) hist[d][j] = hist[d][j-1];
        hist[d][0] = m_n;
        for (int c = 0; c < CH; c++) begin
          flip = 1'b1;
          for (int j = SY; j < SY + DL; j++)
            if (hist[d][j][c] == m_lvl[d][c]) flip = 1'b0;
          if (flip) begin
            if (m_lvl[d][c]) m_r[c] = 1'b1;
            else begin
              m_p[c] = 1'b1;
              press_edge[d][c] = cyc;
            end
            m_lvl[d][c] = ~m_lvl[d][c];
          end else if (m_lvl[d][c] && (cyc - press_edge[d][c] == HD)) begin
            m_l[c] = 1'b1;
          end
        end
      end
      if (d == 0) m_e.hi = {m_lvl[d], m_p, m_r, m_l};
      else        m_e.lo = {m_lvl[d], m_p, m_r, m_l};
    end
    sb.push_back(m_e);
  end

  exp_t mon_e;
  initial forever begin
    @(posedge clk);
    #2;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one at %0t", $time);
    end else begin
      mon_e = sb.pop_front();
      check("dut_hi_outputs", {16'h0, lvl_hi, prs_hi, rel_hi, lng_hi}, {16'h0, mon_e.hi});
      check("dut_lo_outputs", {16'h0, lvl_lo, prs_lo, rel_lo, lng_lo}, {16'h0, mon_e.lo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  logic [5:0]    bounce;
  logic          long_seen, rel_seen;
  int            rem [2][CH];

  initial begin
    raw_hi = '1;
    raw_lo = '1;
    rst_n  = 1'b0;
    ticks(3);
    check("reset_outputs_zero",
          {lvl_hi, prs_hi, rel_hi, lng_hi, lvl_lo, prs_lo, rel_lo, lng_lo}, 32'h0);
    rst_n = 1'b1;
    ticks(5);
    check("post_reset_edge4_press", 32'(prs_hi), 32'h0);
    tick();
    check("post_reset_edge5_level_press", 32'({lvl_hi, prs_hi}), 32'hFF);
    tick();
    check("post_reset_edge6_press", 32'(prs_hi), 32'h0);
    raw_hi = '0;
    ticks(12);

    // Clean press on ch0 with long press and release
    raw_hi = 4'b0001;
    ticks(5);
    check("ch0_edge4_press", 32'(prs_hi[0]), 32'h0);
    tick();
    check("ch0_edge5_level_press", 32'({lvl_hi[0], prs_hi[0]}), 32'h3);
    ticks(9);
    check("ch0_edge14_long", 32'(lng_hi[0]), 32'h0);
    tick();
    check("ch0_edge15_long", 32'(lng_hi[0]), 32'h1);
    ticks(4);
    raw_hi = '0;
    ticks(5);
    check("ch0_edge24_release", 32'(rel_hi[0]), 32'h0);
    tick();
    check("ch0_edge25_release_level", 32'({rel_hi[0], lvl_hi[0]}), 32'h2);
    ticks(5);

    // Glitch shorter than DELAY on ch1
    raw_hi = 4'b0010;
    ticks(3);
    raw_hi = '0;
    ticks(10);
    check("ch1_glitch_level", 32'(lvl_hi[1]), 32'h0);

    // Bounce 1-0-1-1-1-1 on ch1, then held
    bounce = 6'b111101;
    for (int i = 0; i < 6; i++) begin
      raw_hi[1] = bounce[i];
      tick();
    end
    tick();
    check("ch1_bounce_edge6_press", 32'(prs_hi[1]), 32'h0);
    tick();
    check("ch1_bounce_edge7_press", 32'(prs_hi[1]), 32'h1);
    raw_hi[1] = 1'b0;
    ticks(8);

    // Short press on ch2 cancels long press
    raw_hi = 4'b0100;
    ticks(6);
    check("ch2_short_press", 32'(prs_hi[2]), 32'h1);
    ticks(2);
    raw_hi = '0;
    long_seen = 1'b0;
    rel_seen  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      long_seen = long_seen | lng_hi[2];
      rel_seen  = rel_seen | rel_hi[2];
    end
    check("ch2_short_no_long", 32'({rel_seen, long_seen}), 32'h2);

    // Active-low instance: ch3 pulled low
    raw_lo = 4'b0111;
    ticks(5);
    check("lo_ch3_edge4_press", 32'(prs_lo), 32'h0);
    tick();
    check("lo_ch3_edge5_level_press", 32'({lvl_lo, prs_lo}), 32'h88);
    raw_lo = '1;
    ticks(10);

    // Simultaneous press on ch0 and release on ch1
    raw_hi = 4'b0010;
    ticks(10);
    raw_hi = 4'b0001;
    ticks(5);
    tick();
    check("simultaneous_press_release", 32'({prs_hi, rel_hi}), 32'h12);

    // Reset mid-count on ch2 while ch0 is pressed
    raw_hi = 4'b0101;
    ticks(3);
    rst_n = 1'b0;
    #1;
    check("reset_mid_count_outputs", 32'({lvl_hi, prs_hi, rel_hi, lng_hi}), 32'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(5);
    check("after_reset_edge4_press", 32'(prs_hi), 32'h0);
    tick();
    check("after_reset_edge5_press_level", 32'({prs_hi, lvl_hi}), 32'h55);
    raw_hi = '0;
    ticks(12);

    // Randomised run-length stimulus on both instances
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) rem[d][c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < CH; c++) begin
          if (rem[d][c] == 0) begin
            if (d == 0) raw_hi[c] = ~raw_hi[c];
            else        raw_lo[c] = ~raw_lo[c];
            if ($urandom_range(0, 2) == 0) rem[d][c] = int'($urandom_range(1, DL));
            else                           rem[d][c] = int'($urandom_range(DL, 3 * HD));
          end
          rem[d][c] = rem[d][c] - 1;
        end
      end
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
      end
      tick();
    end
    ticks(SY + DL + HD + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
